uart_tx_arbiter: RTL and testbench
==================================

# uart_tx_arbiter

Round-robin arbiter that shares the single UART transmitter between NUM_PORTS byte-stream requesters (CPU MMIO path, debug/trace, bootloader echo, and similar). Each requester presents bytes with a last-of-message flag. The arbiter locks the grant for a whole message so messages from different sources never interleave on the serial line. A MAX_BURST cap forces release so a requester that never asserts last cannot starve the others. It sits directly in front of the transmitter's data_in/data_in_valid/data_in_ready handshake.

## Interface
- NUM_PORTS, 4: number of requesters; legal range 1..16.
- MAX_BURST, 16: maximum bytes per grant; 0 means unlimited, with release on last only.
- ID_W, derived: width of grant_id, equal to max(1, `log2(NUM_PORTS)`) from util.vh.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high.
- in_data  in  8*NUM_PORTS  port p byte at [8p+7:8p].
- in_valid  in  NUM_PORTS  per-port byte valid.
- in_last  in  NUM_PORTS  per-port last-byte-of-message flag; sampled only with valid.
- in_ready  out  NUM_PORTS  per-port accept.
- out_data  out  8  byte to transmitter data_in.
- out_valid  out  1  to transmitter data_in_valid.
- out_ready  in  1  from transmitter data_in_ready.
- busy  out  1  high while a grant is held.
- grant_id  out  ID_W  index of the granted port; 0 when idle.

## Operation
- FSM has two states, IDLE and BUSY. State, grant_id and burst count are registered. Output muxing is combinational from those registers.
- IDLE:
  - in_ready = 0, out_valid = 0, out_data = 0, busy = 0.
  - If any in_valid is high, pick the first asserted port scanning ptr+1, ptr+2, … modulo NUM_PORTS, where ptr is the last granted port.
  - Register that port as grant_id, set ptr to it, clear burst count, and go to BUSY.
- BUSY (granted port g):
  - out_data = in_data[g], out_valid = in_valid[g], in_ready[g] = out_ready, all other in_ready = 0, busy = 1.
  - A byte transfers when out_valid && out_ready. Each transfer increments the burst count.
  - Release to IDLE on the same edge as a transfer when either in_last[g] = 1, or MAX_BURST ≠ 0 and the byte is the MAX_BURST-th of this grant. If both hold, release once.
  - If the granted port drops in_valid mid-message, the grant is held indefinitely. There is no timeout.
- Burst counter is ceil(log2(MAX_BURST+1)) bits wide and saturating-safe; it cannot wrap before release.
- NUM_PORTS = 1: the arbiter degenerates to a pass-through with one IDLE bubble per message.
- No byte is ever buffered. Data integrity relies on the requester holding data stable until ready, per the standard valid/ready rule.

## Timing
- Reset values: state IDLE, ptr = NUM_PORTS-1 (so port 0 wins first), grant_id = 0, burst count = 0, busy = 0, out_valid = 0, in_ready = all 0, out_data = 0.
- Reset mid-message returns to IDLE on the reset edge. A handshake coincident with the reset edge is discarded and not counted.
- Arbitration latency: with a request at edge n while in IDLE, the first out_valid is seen in the cycle after edge n+1 (one IDLE bubble).
- After a release edge, exactly one IDLE cycle occurs before the next grant, even if requests are pending. This gives one bubble between messages.
- in_valid→out_valid and out_ready→in_ready are combinational in BUSY, so there is zero added latency per byte.
- No combinational path exists from in_valid to in_ready.
- A new request never preempts the current grant. Priority changes only at release.

## Test plan
- Single message: port 2 sends 0x48, 0x69 with last on 0x69, transmitter always ready → out_data sequence 0x48, 0x69. Check grant_id = 2 and busy high for exactly 2 cycles, then one IDLE cycle.
- Contention and fairness: ports 0, 1 and 3 each send 3-byte messages, all valid from reset → grant order 0, 1, 3, then 0 again if it re-requests. No byte interleaving within a message.
- Backpressure: transmitter ready only every 10th cycle during a 4-byte message from port 1 → each byte is held stable on out_data until accepted, and in_ready[1] mirrors out_ready.
- Burst cap: MAX_BURST = 4, port 0 streams 10 bytes with no last and port 1 is requesting → port 0 released after 4 bytes, port 1 served, then port 0 resumes with byte 5. Repeat with last on the 4th byte to confirm a single release.
- Reset mid-message: assert reset after 2 of 5 bytes from port 3 → next cycle busy = 0, in_ready = 0, grant_id = 0. Next arbitration favours port 0.
- Stalled requester: port 1 drops valid after byte 1 of 3 for 50 cycles while port 2 requests → grant stays on port 1 with no port 2 bytes, then port 1 completes and port 2 is granted.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter in front of a single UART transmitter.
// A grant is held for a whole message, so messages from different
// requesters never interleave on the serial line. The grant is released
// when the requester marks a byte as last. When MAX_BURST is nonzero, the
// grant is also released after MAX_BURST bytes, so a requester that never
// sends last cannot starve the others. No byte is ever buffered.
//
// state  | meaning
// S_IDLE | no grant held; arbitrate among pending requesters
// S_BUSY | grant_id owns the transmitter until last or burst cap
module uart_tx_arbiter #(
  parameter int NUM_PORTS = 4,
  parameter int MAX_BURST = 16,
  localparam int ID_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [8*NUM_PORTS-1:0] in_data,
  input  logic [NUM_PORTS-1:0]   in_valid,
  input  logic [NUM_PORTS-1:0]   in_last,
  output logic [NUM_PORTS-1:0]   in_ready,
  output logic [7:0]             out_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   busy,
  output logic [ID_W-1:0]        grant_id
);

  localparam int BC_W = (MAX_BURST > 0) ? $clog2(MAX_BURST + 1) : 1;
  localparam logic [BC_W-1:0] BURST_LAST = BC_W'((MAX_BURST > 0) ? MAX_BURST - 1 : 0);
  localparam logic [ID_W-1:0] PTR_RST = ID_W'(NUM_PORTS - 1);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_BUSY = 1'b1;

  logic [0:0]      state;
  logic [ID_W-1:0] ptr;
  logic [BC_W-1:0] burst_cnt;

  logic [7:0]      port_byte [NUM_PORTS];
  logic [ID_W-1:0] pick_id;
  logic            pick_ok;
  logic            xfer;
  logic            rel;
  logic            cap_hit;

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_bytes
    assign port_byte[p] = in_data[8*p+7:8*p];
  end

  // Round-robin pick: first valid port scanning ptr+1, ptr+2, ... with wrap
  always_comb begin
    int              idx_i;
    logic [ID_W-1:0] idx;
    pick_id = '0;
    pick_ok = 1'b0;
    idx_i   = 0;
    idx     = '0;
    for (int i = 1; i <= NUM_PORTS; i++) begin
      idx_i = int'(ptr) + i;
      if (idx_i >= NUM_PORTS) idx_i = idx_i - NUM_PORTS;
      idx = ID_W'(idx_i);
      if (!pick_ok && in_valid[idx]) begin
        pick_ok = 1'b1;
        pick_id = idx;
      end
    end
  end

  // Output mux from the registered grant; in_ready depends only on out_ready
  always_comb begin
    in_ready  = '0;
    out_data  = 8'h00;
    out_valid = 1'b0;
    busy      = (state == S_BUSY);
    if (state == S_BUSY) begin
      in_ready[grant_id] = out_ready;
      out_data           = port_byte[grant_id];
      out_valid          = in_valid[grant_id];
    end
  end

  // Transfer and release qualification; last and burst cap release once together
  always_comb begin
    xfer    = (state == S_BUSY) && in_valid[grant_id] && out_ready;
    cap_hit = (MAX_BURST != 0) && (burst_cnt == BURST_LAST);
    rel     = xfer && (in_last[grant_id] || cap_hit);
  end

  // Grant FSM, round-robin pointer and per-grant byte counter
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      ptr       <= PTR_RST;
      grant_id  <= '0;
      burst_cnt <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (pick_ok) begin
            state     <= S_BUSY;
            grant_id  <= pick_id;
            ptr       <= pick_id;
            burst_cnt <= '0;
          end
        end
        S_BUSY: begin
          if (rel) begin
            state     <= S_IDLE;
            grant_id  <= '0;
            burst_cnt <= '0;
          end else if (xfer && (burst_cnt != '1)) begin
            burst_cnt <= burst_cnt + 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter (4 ports, burst cap of 4 bytes).
module tb_uart_tx_arbiter;

  logic        clk;
  logic        reset;
  logic [31:0] in_data;
  logic [3:0]  in_valid;
  logic [3:0]  in_last;
  logic [3:0]  in_ready;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready;
  logic        busy;
  logic [1:0]  grant_id;

  int checks;
  int failures;

  uart_tx_arbiter #(.NUM_PORTS(4), .MAX_BURST(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy),
    .grant_id  (grant_id)
  );

  always #5 clk = ~clk;

  // requester message tables
  logic [7:0] msg_d [4][16];
  logic       msg_l [4][16];
  int         msg_len [4];
  int         msg_pos [4];
  logic       port_en [4];
  int         rdy_mode;

  // per-cycle trace and transfer log
  logic       tr_busy [256];
  logic [1:0] tr_gid  [256];
  logic       tr_ov   [256];
  logic [7:0] tr_od   [256];
  logic [3:0] tr_ir   [256];
  int         tr_n;
  int         log_port [64];
  logic [7:0] log_data [64];
  int         log_n;

  task automatic clear_tb();
    tr_n = 0;
    log_n = 0;
    rdy_mode = 0;
    for (int p = 0; p < 4; p++) begin
      msg_len[p] = 0;
      msg_pos[p] = 0;
      port_en[p] = 1'b1;
    end
  endtask

  task automatic load(input int p, input int n, input logic [7:0] base, input logic [15:0] lmask);
    for (int i = 0; i < n; i++) begin
      msg_d[p][i] = base + 8'(i);
      msg_l[p][i] = lmask[i];
    end
    msg_len[p] = n;
    msg_pos[p] = 0;
  endtask

  task automatic step();
    logic xf [4];
    for (int p = 0; p < 4; p++) begin
      if (port_en[p] && msg_pos[p] < msg_len[p]) begin
        in_valid[p]      = 1'b1;
        in_data[8*p +: 8] = msg_d[p][msg_pos[p]];
        in_last[p]       = msg_l[p][msg_pos[p]];
      end else begin
        in_valid[p]      = 1'b0;
        in_data[8*p +: 8] = 8'h00;
        in_last[p]       = 1'b0;
      end
    end
    out_ready = (rdy_mode == 0) ? 1'b1 : ((tr_n % 10) == 9);
    @(negedge clk);
    if (tr_n < 256) begin
      tr_busy[tr_n] = busy;
      tr_gid[tr_n]  = grant_id;
      tr_ov[tr_n]   = out_valid;
      tr_od[tr_n]   = out_data;
      tr_ir[tr_n]   = in_ready;
    end
    for (int p = 0; p < 4; p++) begin
      xf[p] = in_valid[p] && in_ready[p];
      if (xf[p] && log_n < 64) begin
        log_port[log_n] = p;
        log_data[log_n] = out_data;
        log_n++;
      end
    end
    @(posedge clk);
    #1;
    if (!reset) begin
      for (int p = 0; p < 4; p++) if (xf[p]) msg_pos[p]++;
    end
    tr_n++;
  endtask

  task automatic apply_reset();
    clear_tb();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    clear_tb();
  endtask

  task automatic test_reset();
    clear_tb();
    reset = 1'b1;
    step();
    step();
    checks++; if (tr_busy[1] !== 1'b0) begin failures++; $display("FAIL reset_busy got=%0b want=0", tr_busy[1]); end
    checks++; if (tr_gid[1] !== 2'd0) begin failures++; $display("FAIL reset_grant_id got=%0d want=0", tr_gid[1]); end
    checks++; if (tr_ov[1] !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%0b want=0", tr_ov[1]); end
    checks++; if (tr_ir[1] !== 4'b0000) begin failures++; $display("FAIL reset_in_ready got=%b want=0000", tr_ir[1]); end
    checks++; if (tr_od[1] !== 8'h00) begin failures++; $display("FAIL reset_out_data got=%h want=00", tr_od[1]); end
    reset = 1'b0;
    step();
    checks++; if (tr_busy[2] !== 1'b0) begin failures++; $display("FAIL idle_no_req_busy got=%0b want=0", tr_busy[2]); end
  endtask

  task automatic test_single();
    int nb;
    apply_reset();
    load(2, 2, 8'h48, 16'h0002);
    msg_d[2][1] = 8'h69;
    for (int i = 0; i < 6; i++) step();
    nb = 0;
    for (int k = 0; k < 6; k++) if (tr_busy[k]) nb++;
    checks++; if (tr_busy[0] !== 1'b0) begin failures++; $display("FAIL single_bubble got=%0b want=0", tr_busy[0]); end
    checks++; if (nb != 2) begin failures++; $display("FAIL single_busy_cycles got=%0d want=2", nb); end
    checks++; if (tr_gid[1] !== 2'd2) begin failures++; $display("FAIL single_grant_id got=%0d want=2", tr_gid[1]); end
    checks++; if (tr_busy[3] !== 1'b0) begin failures++; $display("FAIL single_idle_after got=%0b want=0", tr_busy[3]); end
    checks++; if (log_n != 2) begin failures++; $display("FAIL single_count got=%0d want=2", log_n); end
    checks++; if (log_data[0] !== 8'h48 || log_data[1] !== 8'h69) begin
      failures++; $display("FAIL single_data got=%h,%h want=48,69", log_data[0], log_data[1]);
    end
  endtask

  task automatic test_fairness();
    int         exp_p [12];
    logic [7:0] exp_d [12];
    exp_p = '{0, 0, 0, 1, 1, 1, 3, 3, 3, 0, 0, 0};
    exp_d = '{8'h01, 8'h02, 8'h03, 8'h11, 8'h12, 8'h13, 8'h31, 8'h32, 8'h33, 8'h04, 8'h05, 8'h06};
    apply_reset();
    load(0, 6, 8'h01, 16'h0024);
    load(1, 3, 8'h11, 16'h0004);
    load(3, 3, 8'h31, 16'h0004);
    for (int i = 0; i < 20; i++) step();
    checks++; if (log_n != 12) begin failures++; $display("FAIL fair_count got=%0d want=12", log_n); end
    for (int i = 0; i < 12; i++) begin
      checks++;
      if (log_port[i] != exp_p[i] || log_data[i] !== exp_d[i]) begin
        failures++;
        $display("FAIL fair_xfer[%0d] got=p%0d/%h want=p%0d/%h", i, log_port[i], log_data[i], exp_p[i], exp_d[i]);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [3:0] exp_ir;
    apply_reset();
    rdy_mode = 1;
    load(1, 4, 8'hA1, 16'h0008);
    for (int i = 0; i < 42; i++) step();
    for (int k = 1; k < 40; k++) begin
      exp_ir = ((k % 10) == 9) ? 4'b0010 : 4'b0000;
      checks++;
      if (tr_od[k] !== 8'hA1 + 8'(k / 10) || tr_ov[k] !== 1'b1) begin
        failures++;
        $display("FAIL bp_hold[%0d] got=%h/v%0b want=%h/v1", k, tr_od[k], tr_ov[k], 8'hA1 + 8'(k / 10));
      end
      checks++;
      if (tr_ir[k] !== exp_ir) begin
        failures++; $display("FAIL bp_in_ready[%0d] got=%b want=%b", k, tr_ir[k], exp_ir);
      end
    end
    checks++; if (tr_busy[40] !== 1'b0) begin failures++; $display("FAIL bp_release got=%0b want=0", tr_busy[40]); end
    checks++; if (log_n != 4) begin failures++; $display("FAIL bp_count got=%0d want=4", log_n); end
  endtask

  task automatic test_burst_cap();
    int         exp_p [12];
    logic [7:0] exp_d [12];
    exp_p = '{0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0};
    exp_d = '{8'hC0, 8'hC1, 8'hC2, 8'hC3, 8'hD0, 8'hD1, 8'hC4, 8'hC5, 8'hC6, 8'hC7, 8'hC8, 8'hC9};
    apply_reset();
    load(0, 10, 8'hC0, 16'h0000);
    load(1, 2, 8'hD0, 16'h0002);
    for (int i = 0; i < 20; i++) step();
    checks++; if (log_n != 12) begin failures++; $display("FAIL cap_count got=%0d want=12", log_n); end
    for (int i = 0; i < 12; i++) begin
      checks++;
      if (log_port[i] != exp_p[i] || log_data[i] !== exp_d[i]) begin
        failures++;
        $display("FAIL cap_xfer[%0d] got=p%0d/%h want=p%0d/%h", i, log_port[i], log_data[i], exp_p[i], exp_d[i]);
      end
    end
    checks++; if (tr_busy[5] !== 1'b0) begin failures++; $display("FAIL cap_bubble got=%0b want=0", tr_busy[5]); end
    checks++; if (tr_busy[19] !== 1'b1 || tr_gid[19] !== 2'd0) begin
      failures++; $display("FAIL cap_hold got=b%0b/g%0d want=b1/g0", tr_busy[19], tr_gid[19]);
    end

    apply_reset();
    load(0, 4, 8'hE0, 16'h0008);
    load(1, 1, 8'hF0, 16'h0001);
    for (int i = 0; i < 9; i++) step();
    checks++; if (tr_busy[4] !== 1'b1 || tr_busy[5] !== 1'b0) begin
      failures++; $display("FAIL cap_last_release got=%0b%0b want=10", tr_busy[4], tr_busy[5]);
    end
    checks++; if (tr_busy[6] !== 1'b1 || tr_gid[6] !== 2'd1) begin
      failures++; $display("FAIL cap_last_next got=b%0b/g%0d want=b1/g1", tr_busy[6], tr_gid[6]);
    end
    checks++; if (tr_busy[7] !== 1'b0) begin failures++; $display("FAIL cap_last_end got=%0b want=0", tr_busy[7]); end
    checks++; if (log_n != 5 || log_port[4] != 1 || log_data[4] !== 8'hF0) begin
      failures++; $display("FAIL cap_last_log got=n%0d/p%0d/%h want=n5/p1/f0", log_n, log_port[4], log_data[4]);
    end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    load(3, 5, 8'h50, 16'h0010);
    step();
    step();
    step();
    checks++; if (log_n != 2 || log_port[0] != 3 || log_data[1] !== 8'h51) begin
      failures++; $display("FAIL rmid_pre got=n%0d/p%0d/%h want=n2/p3/51", log_n, log_port[0], log_data[1]);
    end
    reset = 1'b1;
    step();
    step();
    checks++; if (tr_busy[4] !== 1'b0) begin failures++; $display("FAIL rmid_busy got=%0b want=0", tr_busy[4]); end
    checks++; if (tr_ir[4] !== 4'b0000) begin failures++; $display("FAIL rmid_in_ready got=%b want=0000", tr_ir[4]); end
    checks++; if (tr_gid[4] !== 2'd0) begin failures++; $display("FAIL rmid_grant_id got=%0d want=0", tr_gid[4]); end
    reset = 1'b0;
    clear_tb();
    load(0, 1, 8'h60, 16'h0001);
    load(3, 1, 8'h70, 16'h0001);
    for (int i = 0; i < 6; i++) step();
    checks++; if (log_n != 2 || log_port[0] != 0 || log_data[0] !== 8'h60 || log_port[1] != 3) begin
      failures++; $display("FAIL rmid_rearb got=n%0d/p%0d/%h/p%0d want=n2/p0/60/p3", log_n, log_port[0], log_data[0], log_port[1]);
    end
  endtask

  task automatic test_stall();
    int p2_ready;
    apply_reset();
    load(1, 3, 8'h81, 16'h0004);
    load(2, 1, 8'h91, 16'h0001);
    step();
    step();
    port_en[1] = 1'b0;
    for (int i = 0; i < 50; i++) step();
    p2_ready = 0;
    for (int k = 0; k < 52; k++) if (tr_ir[k][2]) p2_ready++;
    checks++; if (log_n != 1) begin failures++; $display("FAIL stall_count got=%0d want=1", log_n); end
    checks++; if (p2_ready != 0) begin failures++; $display("FAIL stall_p2_ready got=%0d want=0", p2_ready); end
    checks++; if (tr_busy[51] !== 1'b1 || tr_gid[51] !== 2'd1 || tr_ov[51] !== 1'b0) begin
      failures++; $display("FAIL stall_hold got=b%0b/g%0d/v%0b want=b1/g1/v0", tr_busy[51], tr_gid[51], tr_ov[51]);
    end
    port_en[1] = 1'b1;
    for (int i = 0; i < 7; i++) step();
    checks++; if (log_n != 4) begin failures++; $display("FAIL stall_total got=%0d want=4", log_n); end
    checks++; if (log_data[1] !== 8'h82 || log_data[2] !== 8'h83 || log_port[2] != 1) begin
      failures++; $display("FAIL stall_resume got=%h,%h/p%0d want=82,83/p1", log_data[1], log_data[2], log_port[2]);
    end
    checks++; if (log_port[3] != 2 || log_data[3] !== 8'h91) begin
      failures++; $display("FAIL stall_next got=p%0d/%h want=p2/91", log_port[3], log_data[3]);
    end
  endtask

  initial begin
    clk       = 1'b0;
    reset     = 1'b1;
    in_data   = '0;
    in_valid  = '0;
    in_last   = '0;
    out_ready = 1'b0;
    checks    = 0;
    failures  = 0;
    test_reset();
    test_single();
    test_fairness();
    test_backpressure();
    test_burst_cap();
    test_reset_mid();
    test_stall();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
